sync_pipe_array: RTL and testbench

- Parametrised multi-channel input synchroniser. It is the successor to the fixed 3-channel two-flop pipe that brings p/w/en in from the asynchronous pin domain.
- Each channel provides:
  - a STAGES-deep flop chain,
  - an optional per-channel glitch filter (stability counter),
  - registered rise/fall pulse outputs.
- Sits between the top-level input pins and the BNN load/control logic. The loader consumes the edge pulses directly instead of building its own edge detectors.

---
 rtl/sync_pipe_array.sv | 116 +++++++++++
 tb/tb_sync_pipe_array.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pipe_array.sv
// ---------------------------------------------------------------------------
// sync_pipe_array
//
// Multi-channel input synchroniser for asynchronous pin-domain signals.
// Each channel passes through a STAGES-deep flop chain, an optional
// stability-counter glitch filter, and a rise/fall edge detector so that
// downstream logic can consume edge pulses directly.
//
// Parameters:
//   N_CH         number of independent channels (1..32)
//   STAGES       synchroniser flop depth per channel (2..4)
//   FILT_CYCLES  glitch-filter length in cycles (0..255), 0 = no filter
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   reset       synchronous active-high reset
//   async_in    asynchronous channel inputs, bit i is channel i
//   sync_out    synchronised (and filtered) level per channel
//   rise        one-cycle pulse when sync_out[i] goes 0 -> 1
//   fall        one-cycle pulse when sync_out[i] goes 1 -> 0
//   any_change  OR of all rise and fall pulses
// ---------------------------------------------------------------------------
module sync_pipe_array #(
    parameter int N_CH        = 3,
    parameter int STAGES      = 2,
    parameter int FILT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] async_in,
    output logic [N_CH-1:0] sync_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            any_change
);

    // Counter width; kept at 1 when the filter is bypassed so the
    // declaration stays legal even though no counter is built.
    localparam int CW = (FILT_CYCLES > 0) ? $clog2(FILT_CYCLES + 1) : 1;

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("sync_pipe_array: STAGES must be in 2..4");
        end
        if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
            $error("sync_pipe_array: N_CH must be in 1..32");
        end
        if (FILT_CYCLES < 0 || FILT_CYCLES > 255) begin : g_bad_filt
            $error("sync_pipe_array: FILT_CYCLES must be in 0..255");
        end
    endgenerate

    logic [N_CH-1:0] level;
    logic [N_CH-1:0] prev;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        // Plain shift chain: nothing may sit between these flops, so the
        // metastability settling time of each stage is a full cycle.
        logic [STAGES-1:0] chain;
        logic              raw;

        always_ff @(posedge clk) begin
            if (reset) begin
                chain <= '0;
            end else begin
                chain <= {chain[STAGES-2:0], async_in[i]};
            end
        end

        assign raw = chain[STAGES-1];

        if (FILT_CYCLES == 0) begin : g_bypass
            assign level[i] = raw;
        end else begin : g_filt
            localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          filt;

            // The counter measures how long raw has disagreed with the
            // accepted level; any return to agreement restarts it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt  <= '0;
                    filt <= 1'b0;
                end else if (raw == filt) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    filt <= raw;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign level[i] = filt;
        end
    end

    // prev clears together with the level registers, so reset itself never
    // produces a fall pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    // Pulses are decoded from registers only; no path from async_in.
    assign sync_out   = level;
    assign rise       = level & ~prev;
    assign fall       = ~level & prev;
    assign any_change = |(rise | fall);

endmodule

// File: tb/tb_sync_pipe_array.sv
module tb_sync_pipe_array;

    logic       clk;
    logic       reset;
    logic [2:0] async_in;

    logic [2:0] s2_sync, s2_rise, s2_fall;
    logic       s2_any;
    logic [2:0] s3_sync, s3_rise, s3_fall;
    logic       s3_any;
    logic [2:0] s4_sync, s4_rise, s4_fall;
    logic       s4_any;
    logic [2:0] f3_sync, f3_rise, f3_fall;
    logic       f3_any;

    int checks;
    int failures;

    sync_pipe_array #(.N_CH(3), .STAGES(2), .FILT_CYCLES(0)) dut_s2 (
        .clk(clk), .reset(reset), .async_in(async_in),
        .sync_out(s2_sync), .rise(s2_rise), .fall(s2_fall), .any_change(s2_any));

    sync_pipe_array #(.N_CH(3), .STAGES(3), .FILT_CYCLES(0)) dut_s3 (
        .clk(clk), .reset(reset), .async_in(async_in),
        .sync_out(s3_sync), .rise(s3_rise), .fall(s3_fall), .any_change(s3_any));

    sync_pipe_array #(.N_CH(3), .STAGES(4), .FILT_CYCLES(0)) dut_s4 (
        .clk(clk), .reset(reset), .async_in(async_in),
        .sync_out(s4_sync), .rise(s4_rise), .fall(s4_fall), .any_change(s4_any));

    sync_pipe_array #(.N_CH(3), .STAGES(2), .FILT_CYCLES(3)) dut_f3 (
        .clk(clk), .reset(reset), .async_in(async_in),
        .sync_out(f3_sync), .rise(f3_rise), .fall(f3_fall), .any_change(f3_any));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        async_in = 3'b000;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        async_in = 3'b111;
        reset    = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (s2_sync !== 3'b111) begin
            failures++;
            $display("FAIL pre_reset_sync got=%b want=111", s2_sync);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (s2_sync !== 3'b000 || s2_rise !== 3'b000 || s2_fall !== 3'b000 || s2_any !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got sync=%b rise=%b fall=%b any=%b want 000/000/000/0",
                     s2_sync, s2_rise, s2_fall, s2_any);
        end
        for (int k = 1; k <= 6; k++) begin
            logic [2:0] e_sync, e_rise;
            tick();
            e_sync = (k >= 2) ? 3'b111 : 3'b000;
            e_rise = (k == 2) ? 3'b111 : 3'b000;
            checks++;
            if (s2_sync !== e_sync || s2_rise !== e_rise || s2_fall !== 3'b000) begin
                failures++;
                $display("FAIL reset_recover k=%0d got sync=%b rise=%b fall=%b want sync=%b rise=%b fall=000",
                         k, s2_sync, s2_rise, s2_fall, e_sync, e_rise);
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        async_in = 3'b001;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (s2_sync[0] !== (k >= 2) || s2_rise[0] !== (k == 2)) begin
                failures++;
                $display("FAIL latency_s2 k=%0d got sync=%b rise=%b", k, s2_sync[0], s2_rise[0]);
            end
            checks++;
            if (s3_sync[0] !== (k >= 3) || s3_rise[0] !== (k == 3)) begin
                failures++;
                $display("FAIL latency_s3 k=%0d got sync=%b rise=%b", k, s3_sync[0], s3_rise[0]);
            end
            checks++;
            if (s4_sync[0] !== (k >= 4) || s4_rise[0] !== (k == 4)) begin
                failures++;
                $display("FAIL latency_s4 k=%0d got sync=%b rise=%b", k, s4_sync[0], s4_rise[0]);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        async_in = 3'b010;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) async_in = 3'b000;
            checks++;
            if (f3_sync[1] !== 1'b0 || f3_rise[1] !== 1'b0) begin
                failures++;
                $display("FAIL glitch_2cyc k=%0d got sync=%b rise=%b want 0/0", k, f3_sync[1], f3_rise[1]);
            end
        end
        async_in = 3'b010;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) async_in = 3'b000;
            checks++;
            if (f3_sync[1] !== (k >= 5 && k <= 7) || f3_rise[1] !== (k == 5) || f3_fall[1] !== (k == 8)) begin
                failures++;
                $display("FAIL glitch_3cyc k=%0d got sync=%b rise=%b fall=%b want sync=%b rise=%b fall=%b",
                         k, f3_sync[1], f3_rise[1], f3_fall[1], (k >= 5 && k <= 7), (k == 5), (k == 8));
            end
        end
    endtask

    task automatic test_coincident();
        do_reset();
        async_in = 3'b101;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (s2_rise !== ((k == 2) ? 3'b101 : 3'b000) || s2_fall !== 3'b000 || s2_any !== (k == 2)) begin
                failures++;
                $display("FAIL coinc_rise k=%0d got rise=%b fall=%b any=%b", k, s2_rise, s2_fall, s2_any);
            end
        end
        async_in = 3'b011;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (s2_rise !== ((k == 2) ? 3'b010 : 3'b000) || s2_fall !== ((k == 2) ? 3'b100 : 3'b000)
                || s2_any !== (k == 2)) begin
                failures++;
                $display("FAIL coinc_swap k=%0d got rise=%b fall=%b any=%b", k, s2_rise, s2_fall, s2_any);
            end
        end
    endtask

    task automatic test_toggle();
        logic hist [10];
        int   n_rise;
        int   n_fall;
        n_rise = 0;
        n_fall = 0;
        for (int j = 0; j < 10; j++) hist[j] = (j % 2 == 0);
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            logic e_sync;
            if (c - 1 < 10) async_in = {hist[c-1], 2'b00};
            else            async_in = 3'b000;
            tick();
            e_sync = (c - 2 >= 0 && c - 2 < 10) ? hist[c-2] : 1'b0;
            checks++;
            if (s2_sync[2] !== e_sync || (s2_rise[2] & s2_fall[2])) begin
                failures++;
                $display("FAIL toggle c=%0d got sync=%b rise=%b fall=%b want sync=%b",
                         c, s2_sync[2], s2_rise[2], s2_fall[2], e_sync);
            end
            if (s2_rise[2] === 1'b1) n_rise++;
            if (s2_fall[2] === 1'b1) n_fall++;
        end
        checks++;
        if (n_rise != 5 || n_fall != 5) begin
            failures++;
            $display("FAIL toggle_counts got rise=%0d fall=%0d want 5/5", n_rise, n_fall);
        end
    endtask

    task automatic test_stable();
        do_reset();
        async_in = 3'b010;
        for (int k = 1; k <= 30; k++) begin
            tick();
            checks++;
            if (s2_rise !== ((k == 2) ? 3'b010 : 3'b000) || s2_fall !== 3'b000 || s2_any !== (k == 2)) begin
                failures++;
                $display("FAIL stable_s2 k=%0d got rise=%b fall=%b any=%b", k, s2_rise, s2_fall, s2_any);
            end
            checks++;
            if (f3_rise !== ((k == 5) ? 3'b010 : 3'b000) || f3_fall !== 3'b000 || f3_any !== (k == 5)) begin
                failures++;
                $display("FAIL stable_f3 k=%0d got rise=%b fall=%b any=%b", k, f3_rise, f3_fall, f3_any);
            end
        end
        // A filter counter left non-zero would shorten this 3-cycle drop's latency.
        async_in = 3'b000;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 3) async_in = 3'b010;
            checks++;
            if (f3_sync[1] !== !(k >= 5 && k <= 7) || f3_fall[1] !== (k == 5) || f3_rise[1] !== (k == 8)) begin
                failures++;
                $display("FAIL stable_cnt k=%0d got sync=%b fall=%b rise=%b", k, f3_sync[1], f3_fall[1], f3_rise[1]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        async_in = 3'b000;
        tick();
        reset = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_coincident();
        test_toggle();
        test_stable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
